// File: rtl/vga_timing_pkg.sv
// Shared constants, phase encoding and output payload for the VGA raster timing generator.
`timescale 1ns/1ps
package vga_timing_pkg;

  localparam int unsigned PIX_W = 10;

  // 640x480@60 (25 MHz pixel rate) timing
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // One-hot raster phase, shared by both axes
  typedef enum logic [3:0] {
    PH_ACTIVE = 4'b0001,
    PH_FP     = 4'b0010,
    PH_SYNC   = 4'b0100,
    PH_BP     = 4'b1000
  } phase_e;

  // Registered output payload
  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             video_active;
    logic [PIX_W-1:0] pixel_x;
    logic [PIX_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;
  } vga_out_t;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned h_total();
    return axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  endfunction

  function automatic int unsigned v_total();
    return axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-enable inputs and raster timing outputs of the VGA timing generator.
`timescale 1ns/1ps
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic             pix_tick;
  logic             enable;
  logic             hsync;
  logic             vsync;
  logic             video_active;
  logic [PIX_W-1:0] pixel_x;
  logic [PIX_W-1:0] pixel_y;
  logic             line_start;
  logic             frame_start;

  // Timing generator side
  modport master (
    input  pix_tick, enable,
    output hsync, vsync, video_active, pixel_x, pixel_y, line_start, frame_start
  );

  // Consumer / pixel-enable source side
  modport slave (
    output pix_tick, enable,
    input  hsync, vsync, video_active, pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus one-hot phase FSM. Exposes the
// post-step values combinationally so the top can register them on the same edge.
`timescale 1ns/1ps
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             step,
  output logic [PIX_W-1:0] count_nxt_c,
  output logic             wrap_c,
  output logic             sync_nxt_c,
  output logic             active_nxt_c
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned CW    = $clog2(TOTAL);

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] AT_FP   = CW'(ACTIVE);
  localparam logic [CW-1:0] AT_SYNC = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] AT_BP   = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q, count_nxt;
  phase_e        phase_q, phase_nxt;

  // Next position and phase; illegal phase codes fall back to the reset position
  always_comb begin
    count_nxt = count_q;
    phase_nxt = phase_q;
    wrap_c    = 1'b0;
    if (step) begin
      if (count_q >= LAST) begin
        count_nxt = '0;
        wrap_c    = 1'b1;
      end else begin
        count_nxt = count_q + CW'(1);
      end
      case (phase_q)
        PH_ACTIVE: if (count_nxt == AT_FP)   phase_nxt = PH_FP;
        PH_FP:     if (count_nxt == AT_SYNC) phase_nxt = PH_SYNC;
        PH_SYNC:   if (count_nxt == AT_BP)   phase_nxt = PH_BP;
        PH_BP:     if (wrap_c)               phase_nxt = PH_ACTIVE;
        default: begin
          count_nxt = LAST;
          phase_nxt = PH_BP;
          wrap_c    = 1'b0;
        end
      endcase
    end
  end

  // Counter and phase state; reset parks on the last position so the first step lands on 0
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= LAST;
      phase_q <= PH_BP;
    end else begin
      count_q <= count_nxt;
      phase_q <= phase_nxt;
    end
  end

  assign count_nxt_c  = PIX_W'(count_nxt);
  assign sync_nxt_c   = (phase_nxt == PH_SYNC);
  assign active_nxt_c = (phase_nxt == PH_ACTIVE);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical axis counters, registered sync,
// video-active, pixel coordinates and line/frame strobes.
`timescale 1ns/1ps
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input logic             clk_in,
  input logic             reset_n,
  vga_timing_gen_if.master bus
);

  localparam vga_out_t OUT_RST = '{
    hsync:        ~HSYNC_POL,
    vsync:        ~VSYNC_POL,
    video_active: 1'b0,
    pixel_x:      '0,
    pixel_y:      '0,
    line_start:   1'b0,
    frame_start:  1'b0
  };

  logic             adv_c;
  logic [PIX_W-1:0] h_nxt_c, v_nxt_c;
  logic             h_wrap_c, v_wrap_c;
  logic             h_sync_c, v_sync_c;
  logic             h_act_c, v_act_c;
  vga_out_t         out_q;

  assign adv_c = bus.pix_tick & bus.enable;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .step         (adv_c),
    .count_nxt_c  (h_nxt_c),
    .wrap_c       (h_wrap_c),
    .sync_nxt_c   (h_sync_c),
    .active_nxt_c (h_act_c)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .step         (h_wrap_c),
    .count_nxt_c  (v_nxt_c),
    .wrap_c       (v_wrap_c),
    .sync_nxt_c   (v_sync_c),
    .active_nxt_c (v_act_c)
  );

  // Outputs follow the new position on advancing edges; strobes last one cycle
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= OUT_RST;
    end else if (adv_c) begin
      out_q <= '{
        hsync:        h_sync_c ? HSYNC_POL : ~HSYNC_POL,
        vsync:        v_sync_c ? VSYNC_POL : ~VSYNC_POL,
        video_active: h_act_c & v_act_c,
        pixel_x:      h_nxt_c,
        pixel_y:      v_nxt_c,
        line_start:   h_wrap_c,
        frame_start:  h_wrap_c & v_wrap_c
      };
    end else begin
      out_q.line_start  <= 1'b0;
      out_q.frame_start <= 1'b0;
    end
  end

  assign bus.hsync        = out_q.hsync;
  assign bus.vsync        = out_q.vsync;
  assign bus.video_active = out_q.video_active;
  assign bus.pixel_x      = out_q.pixel_x;
  assign bus.pixel_y      = out_q.pixel_y;
  assign bus.line_start   = out_q.line_start;
  assign bus.frame_start  = out_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: dut_a uses 640x480 defaults, dut_b a tiny raster
// (15x13, active-high hsync) so whole frames and mid-frame resets fit a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_active;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset_n = 1'b0;
  logic pix_tick = 1'b0;
  logic enable = 1'b0;

  vga_timing_gen_if a_if();
  vga_timing_gen_if b_if();

  assign a_if.pix_tick = pix_tick;
  assign a_if.enable   = enable;
  assign b_if.pix_tick = pix_tick;
  assign b_if.enable   = enable;

  vga_timing_gen dut_a (.clk_in(clk_in), .reset_n(reset_n), .bus(a_if.master));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut_b (.clk_in(clk_in), .reset_n(reset_n), .bus(b_if.master));

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  int ah, av, bh, bv;
  exp_t ea, eb;
  exp_t ma, mb;
  int cyc = 0;
  int last_ls_a = -1;
  int last_fs_b = -1;
  int per_ls_a = 0;
  int per_fs_b = 0;
  int hs_low = 0;
  bit cnt_hs = 1'b0;

  function automatic exp_t rst_exp(input bit hp, input bit vp);
    exp_t e;
    e = '0;
    e.hsync = !hp;
    e.vsync = !vp;
    return e;
  endfunction

  function automatic exp_t mk(input int h, input int v, input int ha, input int hf, input int hsw,
                              input int va, input int vf, input int vsw, input bit hp, input bit vp);
    exp_t e;
    e.pixel_x      = 10'(h);
    e.pixel_y      = 10'(v);
    e.video_active = (h < ha) && (v < va);
    e.hsync        = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    e.vsync        = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    e.line_start   = (h == 0);
    e.frame_start  = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t get_a();
    return {a_if.hsync, a_if.vsync, a_if.video_active, a_if.pixel_x, a_if.pixel_y,
            a_if.line_start, a_if.frame_start};
  endfunction

  function automatic exp_t get_b();
    return {b_if.hsync, b_if.vsync, b_if.video_active, b_if.pixel_x, b_if.pixel_y,
            b_if.line_start, b_if.frame_start};
  endfunction

  task automatic chk(input string nm, input exp_t g, input exp_t e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s @%0t got hs=%b vs=%b va=%b x=%0d y=%0d ls=%b fs=%b want hs=%b vs=%b va=%b x=%0d y=%0d ls=%b fs=%b",
               nm, $time, g.hsync, g.vsync, g.video_active, g.pixel_x, g.pixel_y, g.line_start, g.frame_start,
               e.hsync, e.vsync, e.video_active, e.pixel_x, e.pixel_y, e.line_start, e.frame_start);
    end
  endtask

  task automatic chk_int(input string nm, input int g, input int e);
    total++;
    if (g != e) begin
      bad++;
      $display("FAIL %s @%0t got=%0d want=%0d", nm, $time, g, e);
    end
  endtask

  // Apply one cycle of stimulus and queue what both DUTs must show after the next edge
  task automatic drive(input bit rst, input bit tick, input bit en);
    @(negedge clk_in);
    reset_n  = !rst;
    pix_tick = tick;
    enable   = en;
    if (rst) begin
      ah = 799; av = 524; bh = 14; bv = 12;
      ea = rst_exp(1'b0, 1'b0);
      eb = rst_exp(1'b1, 1'b0);
    end else if (tick && en) begin
      ah = (ah == 799) ? 0 : ah + 1;
      if (ah == 0) av = (av == 524) ? 0 : av + 1;
      bh = (bh == 14) ? 0 : bh + 1;
      if (bh == 0) bv = (bv == 12) ? 0 : bv + 1;
      ea = mk(ah, av, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
      eb = mk(bh, bv, 8, 2, 3, 6, 2, 2, 1'b1, 1'b0);
    end else begin
      ea.line_start = 1'b0; ea.frame_start = 1'b0;
      eb.line_start = 1'b0; eb.frame_start = 1'b0;
    end
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  // Monitor: compare each queued expectation against the outputs after its edge
  always @(posedge clk_in) begin
    #1;
    cyc++;
    if (qa.size() > 0) begin
      ma = qa.pop_front();
      chk("out_a", get_a(), ma);
    end
    if (qb.size() > 0) begin
      mb = qb.pop_front();
      chk("out_b", get_b(), mb);
    end
    if (cnt_hs && !a_if.hsync) hs_low++;
    if (a_if.line_start) begin
      if (last_ls_a >= 0 && per_ls_a != 0) chk_int("line_period_a", cyc - last_ls_a, per_ls_a);
      last_ls_a = cyc;
    end
    if (b_if.frame_start) begin
      if (last_fs_b >= 0 && per_fs_b != 0) chk_int("frame_period_b", cyc - last_fs_b, per_fs_b);
      last_fs_b = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog @%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held, then released with no tick: outputs stay at reset values
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);

    // First tick lands on (0,0) with both strobes
    per_ls_a = 3200;
    drive(1'b0, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b1);

    // One full line with a tick every 4th cycle
    cnt_hs = 1'b1;
    for (int i = 0; i < 800; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      repeat (3) drive(1'b0, 1'b0, 1'b1);
    end
    cnt_hs = 1'b0;
    per_ls_a = 0;
    chk_int("hsync_low_cycles_a", hs_low, 384);

    // Tick tied high: two small frames on dut_b
    last_fs_b = -1;
    per_fs_b = 195;
    repeat (400) drive(1'b0, 1'b1, 1'b1);
    per_fs_b = 0;

    // Advance dut_a to x=700, freeze for 10 ticks, then resume at 701
    repeat (300) drive(1'b0, 1'b1, 1'b1);
    chk_int("model_x_a", ah, 700);
    repeat (10) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);

    // Mid-frame reset: run dut_b to (5,3), assert reset between edges
    for (int k = 0; k < 200 && !(bh == 5 && bv == 3); k++) drive(1'b0, 1'b1, 1'b1);
    chk_int("model_pos_b", bh * 100 + bv, 503);
    @(posedge clk_in);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_a", get_a(), rst_exp(1'b0, 1'b0));
    chk("async_rst_b", get_b(), rst_exp(1'b1, 1'b0));
    repeat (2) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk_in);
    chk_int("queue_drain", qa.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
